// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolve queue: result packets, queue entries,
// the optional debug view, and sizing constants.
package branch_resolve_pkg;

  localparam int unsigned B_MASK_WIDTH  = 4;
  localparam int unsigned ADDR_WIDTH    = 32;
  localparam int unsigned DEF_NUM_BR_FU = 2;
  localparam int unsigned DEF_RQ_DEPTH  = 4;
  localparam int unsigned RQ_DEPTH_BITS = $clog2(DEF_RQ_DEPTH);

  typedef logic [B_MASK_WIDTH-1:0] B_MASK;
  typedef logic [ADDR_WIDTH-1:0]   ADDR;

  typedef struct packed {
    logic  valid;
    ADDR   pc;
    B_MASK b_mm;
    B_MASK b_mask;
    logic  taken;
    ADDR   target;
    logic  pred_taken;
    ADDR   pred_target;
  } BR_RESULT_PACKET;

  typedef struct packed {
    logic  valid;
    ADDR   pc;
    B_MASK b_mm;
    B_MASK b_mask;
    logic  taken;
    ADDR   target;
    logic  pred_taken;
    ADDR   pred_target;
    logic  mispred;
  } RQ_ENTRY;

  typedef struct packed {
    RQ_ENTRY [DEF_RQ_DEPTH-1:0]  entries;
    logic    [DEF_RQ_DEPTH-1:0]  valid;
    logic    [RQ_DEPTH_BITS-1:0] sel_idx;
    RQ_ENTRY [DEF_RQ_DEPTH-1:0]  next_entries;
  } BR_RESOLVE_DEBUG;

  // Mispredict is decided once, at enqueue, and carried with the entry.
  function automatic RQ_ENTRY to_entry(input BR_RESULT_PACKET p);
    RQ_ENTRY e;
    e.valid       = p.valid;
    e.pc          = p.pc;
    e.b_mm        = p.b_mm;
    e.b_mask      = p.b_mask;
    e.taken       = p.taken;
    e.target      = p.target;
    e.pred_taken  = p.pred_taken;
    e.pred_target = p.pred_target;
    e.mispred     = (p.taken != p.pred_taken) || (p.taken && (p.target != p.pred_target));
    return e;
  endfunction

endpackage

// File: rtl/branch_resolve_rq_select.sv
// Combinational picker: oldest valid mispredict first, otherwise the
// lowest-index valid correct entry. Returns a one-hot grant.
module br_rq_select
  import branch_resolve_pkg::*;
#(
  parameter int unsigned RQ_DEPTH = DEF_RQ_DEPTH
) (
  input  RQ_ENTRY             entries [RQ_DEPTH],
  output logic [RQ_DEPTH-1:0] grant
);

  logic [RQ_DEPTH-1:0] mis_cand;
  logic [RQ_DEPTH-1:0] oldest;
  logic                younger_than_other;
  logic                found;

  always_comb begin
    mis_cand           = '0;
    oldest             = '0;
    younger_than_other = 1'b0;
    found              = 1'b0;
    grant              = '0;

    for (int unsigned i = 0; i < RQ_DEPTH; i++) begin
      mis_cand[i] = entries[i].valid && entries[i].mispred;
    end

    // An entry is oldest when its b_mask names no other pending mispredict.
    for (int unsigned i = 0; i < RQ_DEPTH; i++) begin
      younger_than_other = 1'b0;
      for (int unsigned j = 0; j < RQ_DEPTH; j++) begin
        if (j != i && mis_cand[j] && |(entries[i].b_mask & entries[j].b_mm)) begin
          younger_than_other = 1'b1;
        end
      end
      oldest[i] = mis_cand[i] && !younger_than_other;
    end

    for (int unsigned i = 0; i < RQ_DEPTH; i++) begin
      if (!found && oldest[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end

    for (int unsigned i = 0; i < RQ_DEPTH; i++) begin
      if (!found && entries[i].valid && !entries[i].mispred) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve queue: buffers branch FU results and issues one resolution
// per cycle to the branch stack. Define BR_RESOLVE_DEBUG_EN for a debug port.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned NUM_BR_FU = DEF_NUM_BR_FU,
  parameter int unsigned RQ_DEPTH  = DEF_RQ_DEPTH
) (
  input  logic            clock,
  input  logic            reset,
  input  BR_RESULT_PACKET br_result [NUM_BR_FU],
  output logic            br_ready,
  output B_MASK           b_mm_resolve,
  output logic            b_mm_mispred,
  output ADDR             redirect_pc,
  output logic            bp_upd_valid,
  output ADDR             bp_upd_pc,
  output logic            bp_upd_taken,
  output ADDR             bp_upd_target
`ifdef BR_RESOLVE_DEBUG_EN
  ,
  output BR_RESOLVE_DEBUG br_resolve_debug
`endif
);

  RQ_ENTRY             rq      [RQ_DEPTH];
  RQ_ENTRY             rq_next [RQ_DEPTH];
  RQ_ENTRY             sel;
  RQ_ENTRY             inc;
  logic [RQ_DEPTH-1:0] grant;
  logic [RQ_DEPTH-1:0] used;
  logic                issue;
  logic                keep;
  logic                placed;
  int unsigned         free_cnt;

  br_rq_select #(.RQ_DEPTH(RQ_DEPTH)) u_select (
    .entries (rq),
    .grant   (grant)
  );

  always_comb begin
    sel      = '0;
    free_cnt = 0;
    for (int unsigned i = 0; i < RQ_DEPTH; i++) begin
      if (grant[i]) sel = rq[i];
      if (!rq[i].valid) free_cnt = free_cnt + 1;
    end
  end

  assign issue    = |grant;
  assign br_ready = (free_cnt >= NUM_BR_FU);

  // sel is all-zero when nothing is granted, so every output idles at 0.
  always_comb begin
    b_mm_resolve  = sel.b_mm;
    b_mm_mispred  = sel.valid && sel.mispred;
    redirect_pc   = '0;
    if (b_mm_mispred) redirect_pc = sel.taken ? sel.target : sel.pc + ADDR'(4);
    bp_upd_valid  = |sel.b_mm;
    bp_upd_pc     = sel.pc;
    bp_upd_taken  = sel.taken;
    bp_upd_target = sel.target;
  end

  always_comb begin
    rq_next = rq;
    used    = '0;
    inc     = '0;
    keep    = 1'b0;
    placed  = 1'b0;

    for (int unsigned i = 0; i < RQ_DEPTH; i++) begin
      if (grant[i]) begin
        rq_next[i].valid = 1'b0;
      end else if (rq[i].valid && issue) begin
        if (sel.mispred) begin
          if (|(rq[i].b_mask & sel.b_mm)) rq_next[i].valid = 1'b0;
        end else begin
          rq_next[i].b_mask = rq[i].b_mask & ~sel.b_mm;
        end
      end
    end

    // Only slots free at the start of the cycle are filled; the slot
    // vacated by this cycle's issue becomes usable next cycle.
    for (int unsigned l = 0; l < NUM_BR_FU; l++) begin
      inc  = to_entry(br_result[l]);
      keep = br_ready && inc.valid;
      if (issue) begin
        if (sel.mispred) begin
          if (|(inc.b_mask & sel.b_mm)) keep = 1'b0;
        end else begin
          inc.b_mask = inc.b_mask & ~sel.b_mm;
        end
      end
      placed = 1'b0;
      for (int unsigned i = 0; i < RQ_DEPTH; i++) begin
        if (keep && !placed && !rq[i].valid && !used[i]) begin
          rq_next[i] = inc;
          used[i]    = 1'b1;
          placed     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < RQ_DEPTH; i++) rq[i] <= '0;
    end else begin
      rq <= rq_next;
    end
  end

`ifdef BR_RESOLVE_DEBUG_EN
  always_comb begin
    br_resolve_debug = '0;
    for (int unsigned i = 0; i < DEF_RQ_DEPTH; i++) begin
      br_resolve_debug.entries[i]      = rq[i];
      br_resolve_debug.valid[i]        = rq[i].valid;
      br_resolve_debug.next_entries[i] = rq_next[i];
      if (grant[i]) br_resolve_debug.sel_idx = RQ_DEPTH_BITS'(i);
    end
  end
`endif

  for (genvar l = 0; l < NUM_BR_FU; l++) begin : g_lane_chk
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      br_result[l].valid |-> br_ready);
    a_lane_onehot: assert property (@(posedge clock) disable iff (reset)
      br_result[l].valid |-> $onehot(br_result[l].b_mm));
  end

  for (genvar i = 0; i < RQ_DEPTH; i++) begin : g_entry_chk
    a_entry_onehot: assert property (@(posedge clock) disable iff (reset)
      rq[i].valid |-> $onehot(rq[i].b_mm));
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a slot-list reference model
// checked every cycle, plus literal expectations per scenario.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic            clock;
  logic            reset;
  BR_RESULT_PACKET br_result [2];
  logic            br_ready;
  B_MASK           b_mm_resolve;
  logic            b_mm_mispred;
  ADDR             redirect_pc;
  logic            bp_upd_valid;
  ADDR             bp_upd_pc;
  logic            bp_upd_taken;
  ADDR             bp_upd_target;
`ifdef BR_RESOLVE_DEBUG_EN
  BR_RESOLVE_DEBUG dbg;
`endif

  int errors = 0;
  int checks = 0;

  branch_resolve #(.NUM_BR_FU(2), .RQ_DEPTH(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .br_result     (br_result),
    .br_ready      (br_ready),
    .b_mm_resolve  (b_mm_resolve),
    .b_mm_mispred  (b_mm_mispred),
    .redirect_pc   (redirect_pc),
    .bp_upd_valid  (bp_upd_valid),
    .bp_upd_pc     (bp_upd_pc),
    .bp_upd_taken  (bp_upd_taken),
    .bp_upd_target (bp_upd_target)
`ifdef BR_RESOLVE_DEBUG_EN
    ,
    .br_resolve_debug (dbg)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit [3:0]  mm;
    bit [3:0]  mask;
    bit        taken;
    bit [31:0] tgt;
    bit        mis;
  } ment_t;

  ment_t m [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference choice: a mispredict whose mask names no other live
  // mispredict is the oldest; failing that, the first correct slot.
  function automatic int pick();
    bit [3:0] others;
    for (int i = 0; i < 4; i++) begin
      if (m[i].v && m[i].mis) begin
        others = '0;
        for (int j = 0; j < 4; j++)
          if (j != i && m[j].v && m[j].mis) others |= m[j].mm;
        if ((m[i].mask & others) == 4'b0) return i;
      end
    end
    for (int i = 0; i < 4; i++)
      if (m[i].v && !m[i].mis) return i;
    return -1;
  endfunction

  function automatic int nfree();
    int n = 0;
    for (int i = 0; i < 4; i++) if (!m[i].v) n++;
    return n;
  endfunction

  always @(posedge clock) begin : model_upd
    int        k;
    int        nf;
    bit [3:0]  x;
    bit        xmis;
    bit        pre_v [4];
    bit        claimed [4];
    bit        ok;
    ment_t     r;
    if (reset) begin
      for (int i = 0; i < 4; i++) m[i].v = 1'b0;
    end else begin
      k  = pick();
      nf = nfree();
      for (int i = 0; i < 4; i++) begin
        pre_v[i]   = m[i].v;
        claimed[i] = 1'b0;
      end
      x = '0; xmis = 1'b0;
      if (k >= 0) begin
        x    = m[k].mm;
        xmis = m[k].mis;
        m[k].v = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (m[i].v) begin
            if (xmis && (m[i].mask & x) != 0) m[i].v = 1'b0;
            else if (!xmis) m[i].mask &= ~x;
          end
        end
      end
      if (nf >= 2) begin
        for (int l = 0; l < 2; l++) begin
          if (br_result[l].valid) begin
            r.v     = 1'b1;
            r.pc    = br_result[l].pc;
            r.mm    = br_result[l].b_mm;
            r.mask  = br_result[l].b_mask;
            r.taken = br_result[l].taken;
            r.tgt   = br_result[l].target;
            r.mis   = (br_result[l].taken != br_result[l].pred_taken) ||
                      (br_result[l].taken && br_result[l].target != br_result[l].pred_target);
            ok = 1'b1;
            if (k >= 0 && xmis && (r.mask & x) != 0) ok = 1'b0;
            if (k >= 0 && !xmis) r.mask &= ~x;
            for (int i = 0; i < 4; i++) begin
              if (ok && !pre_v[i] && !claimed[i]) begin
                m[i] = r;
                claimed[i] = 1'b1;
                ok = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  always @(negedge clock) begin : cmp
    int        k;
    bit [3:0]  e_mm;
    bit        e_mis;
    bit [31:0] e_redir;
    bit [31:0] e_pc;
    bit [31:0] e_tgt;
    bit        e_tk;
    k = pick();
    e_mm = '0; e_mis = 1'b0; e_redir = '0; e_pc = '0; e_tgt = '0; e_tk = 1'b0;
    if (k >= 0) begin
      e_mm  = m[k].mm;
      e_mis = m[k].mis;
      e_pc  = m[k].pc;
      e_tgt = m[k].tgt;
      e_tk  = m[k].taken;
      if (e_mis) e_redir = m[k].taken ? m[k].tgt : m[k].pc + 32'd4;
    end
    chk("model_resolve", b_mm_resolve, e_mm);
    chk("model_mispred", b_mm_mispred, e_mis);
    chk("model_redirect", redirect_pc, e_redir);
    chk("model_upd_valid", bp_upd_valid, e_mm != 0);
    chk("model_upd_pc", bp_upd_pc, e_pc);
    chk("model_upd_taken", bp_upd_taken, e_tk);
    chk("model_upd_target", bp_upd_target, e_tgt);
    chk("model_ready", br_ready, nfree() >= 2);
  end

  task automatic lane(input int l, input logic [31:0] pc, input logic [3:0] mm,
                      input logic [3:0] mask, input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt);
    br_result[l].valid       = 1'b1;
    br_result[l].pc          = pc;
    br_result[l].b_mm        = mm;
    br_result[l].b_mask      = mask;
    br_result[l].taken       = tk;
    br_result[l].target      = tgt;
    br_result[l].pred_taken  = ptk;
    br_result[l].pred_target = ptgt;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    br_result[0] = '0;
    br_result[1] = '0;
  endtask

  initial begin
    reset = 1'b1;
    br_result[0] = '0;
    br_result[1] = '0;
    step();
    step();
    reset = 1'b0;

    @(negedge clock);
    chk("rst_resolve", b_mm_resolve, 4'b0000);
    chk("rst_mispred", b_mm_mispred, 1'b0);
    chk("rst_upd_valid", bp_upd_valid, 1'b0);
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_ready", br_ready, 1'b1);

    // Correct branch
    step();
    lane(0, 32'h10, 4'b0010, 4'b0000, 1'b1, 32'h100, 1'b1, 32'h100);
    step();
    @(negedge clock);
    chk("t1_resolve", b_mm_resolve, 4'b0010);
    chk("t1_mispred", b_mm_mispred, 1'b0);
    chk("t1_upd_taken", bp_upd_taken, 1'b1);
    chk("t1_upd_target", bp_upd_target, 32'h100);
    step();
    @(negedge clock);
    chk("t1_empty", b_mm_resolve, 4'b0000);

    // Direction mispredict
    lane(0, 32'h40, 4'b0001, 4'b0000, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    @(negedge clock);
    chk("t2_resolve", b_mm_resolve, 4'b0001);
    chk("t2_mispred", b_mm_mispred, 1'b1);
    chk("t2_redirect", redirect_pc, 32'h44);

    // Same-cycle pair: younger mispredict goes first
    step();
    lane(0, 32'h50, 4'b0001, 4'b0000, 1'b1, 32'h60, 1'b1, 32'h60);
    lane(1, 32'h54, 4'b0100, 4'b0001, 1'b1, 32'h70, 1'b1, 32'h74);
    step();
    @(negedge clock);
    chk("t3_first", b_mm_resolve, 4'b0100);
    chk("t3_first_mis", b_mm_mispred, 1'b1);
    chk("t3_redirect", redirect_pc, 32'h70);
    step();
    @(negedge clock);
    chk("t3_second", b_mm_resolve, 4'b0001);
    chk("t3_second_mis", b_mm_mispred, 1'b0);

    // Younger squash: A issues, queued C and incoming B are dropped
    step();
    lane(0, 32'h80, 4'b0001, 4'b0000, 1'b0, 32'h90, 1'b1, 32'h90);
    lane(1, 32'h88, 4'b1000, 4'b0001, 1'b0, 32'h98, 1'b1, 32'h98);
    step();
    lane(0, 32'h84, 4'b0100, 4'b0001, 1'b1, 32'h94, 1'b1, 32'h94);
    @(negedge clock);
    chk("t4_resolve", b_mm_resolve, 4'b0001);
    chk("t4_mispred", b_mm_mispred, 1'b1);
    chk("t4_redirect", redirect_pc, 32'h84);
    step();
    @(negedge clock);
    chk("t4_squash1", b_mm_resolve, 4'b0000);
    step();
    @(negedge clock);
    chk("t4_squash2", b_mm_resolve, 4'b0000);

    // Backpressure
    step();
    lane(0, 32'h100, 4'b0001, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    lane(1, 32'h104, 4'b0010, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    lane(0, 32'h108, 4'b0100, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    lane(1, 32'h10c, 4'b1000, 4'b0000, 1'b1, 32'h200, 1'b0, 32'h0);
    @(negedge clock);
    chk("t5_ready_occ2", br_ready, 1'b1);
    chk("t5_resolve_a", b_mm_resolve, 4'b0001);
    step();
    @(negedge clock);
    chk("t5_ready_occ3", br_ready, 1'b0);
    chk("t5_resolve_b", b_mm_resolve, 4'b1000);
    chk("t5_redirect", redirect_pc, 32'h200);
    step();
    @(negedge clock);
    chk("t5_ready_back", br_ready, 1'b1);
    chk("t5_resolve_c", b_mm_resolve, 4'b0010);
    step();
    step();
    @(negedge clock);
    chk("t5_drained", b_mm_resolve, 4'b0000);

    // Correct issue clears its bit from queued and incoming masks
    lane(0, 32'h300, 4'b0001, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    lane(1, 32'h304, 4'b0010, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    lane(0, 32'h308, 4'b0100, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0);
    lane(1, 32'h30c, 4'b0001, 4'b0000, 1'b1, 32'h3b0, 1'b0, 32'h0);
    @(negedge clock);
    chk("t7_x", b_mm_resolve, 4'b0001);
    step();
    @(negedge clock);
    chk("t7_w", b_mm_resolve, 4'b0001);
    chk("t7_w_mis", b_mm_mispred, 1'b1);
    chk("t7_w_redirect", redirect_pc, 32'h3b0);
    step();
    @(negedge clock);
    chk("t7_y_kept", b_mm_resolve, 4'b0010);
    step();
    @(negedge clock);
    chk("t7_v_kept", b_mm_resolve, 4'b0100);
    step();

    // Reset with three entries queued
    lane(0, 32'h400, 4'b0001, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    lane(1, 32'h404, 4'b0010, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    lane(0, 32'h408, 4'b0100, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    lane(1, 32'h40c, 4'b1000, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    reset = 1'b1;
    @(negedge clock);
    chk("t6_ready_full", br_ready, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("t6_resolve", b_mm_resolve, 4'b0000);
    chk("t6_ready", br_ready, 1'b1);
    step();
    @(negedge clock);
    chk("t6_no_stale", b_mm_resolve, 4'b0000);
    chk("t6_no_stale_upd", bp_upd_valid, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
